// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: the priority state encoding
// and the default widths used by the arbiter and its scoreboard.
package wb_arbiter_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int ADDR_W_DEF     = 6;
  localparam int STARVE_MAX_DEF = 4;

  localparam logic [0:0] A_PRI = 1'b0;
  localparam logic [0:0] B_PRI = 1'b1;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on B-unit issue,
// cleared when the B result is written back. Two combinational read ports.
module wb_scoreboard #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] q1,
  input  logic [ADDR_W-1:0] q2,
  output logic              busy1,
  output logic              busy2
);

  localparam int NREG = 2 ** ADDR_W;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_d;

  // Set is applied after clear so a same-cycle set/clear leaves the bit set.
  always_comb begin
    busy_d = busy;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en && (set_addr != '0)) busy_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_d;
  end

  assign busy1 = (q1 != '0) && busy[q1];
  assign busy2 = (q2 != '0) && busy[q2];

endmodule

// File: rtl/wb_arbiter.sv
// Two-source writeback arbiter onto the single regfile write port, with
// starvation-bounded priority for the long-latency B unit.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic [ADDR_W-1:0] q1,
  input  logic [ADDR_W-1:0] q2,
  output logic              busy1,
  output logic              busy2,
  output logic              we3,
  output logic [ADDR_W-1:0] a3,
  output logic [DATA_W-1:0] wd3
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [0:0]    state, state_d;
  logic [CW-1:0] starve_cnt, cnt_d;
  logic          a_xfer, b_xfer, starving;

  always_comb begin
    if (state == A_PRI) begin
      a_ready = 1'b1;
      b_ready = !a_valid;
    end else begin
      b_ready = 1'b1;
      a_ready = !b_valid;
    end
  end

  assign a_xfer   = a_valid && a_ready;
  assign b_xfer   = b_valid && b_ready;
  assign starving = (state == A_PRI) && b_valid && !b_ready;

  always_comb begin
    cnt_d = starve_cnt;
    if (b_xfer)                               cnt_d = '0;
    else if (starving && starve_cnt != CNT_MAX) cnt_d = starve_cnt + 1'b1;
  end

  // B_PRI always lasts one cycle: either B transfers or it has nothing to send.
  always_comb begin
    state_d = state;
    if (state == A_PRI) begin
      if (starving && cnt_d == CNT_MAX) state_d = B_PRI;
    end else if (b_xfer || !b_valid) begin
      state_d = A_PRI;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= A_PRI;
      starve_cnt <= '0;
      we3        <= 1'b0;
      a3         <= '0;
      wd3        <= '0;
    end else begin
      state      <= state_d;
      starve_cnt <= cnt_d;
      we3        <= 1'b0;
      if (a_xfer) begin
        we3 <= (a_rd != '0);
        a3  <= a_rd;
        wd3 <= a_data;
      end else if (b_xfer) begin
        we3 <= (b_rd != '0);
        a3  <= b_rd;
        wd3 <= b_data;
      end
    end
  end

  wb_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (iss_valid),
    .set_addr (iss_rd),
    .clr_en   (b_xfer),
    .clr_addr (b_rd),
    .q1       (q1),
    .q2       (q2),
    .busy1    (busy1),
    .busy2    (busy2)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed, table-driven bench for wb_arbiter: handshake, write latency,
// starvation rotation, scoreboard set/clear and mid-starvation reset.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, iss_valid;
  logic [5:0]  a_rd, b_rd, iss_rd, q1, q2, a3;
  logic [31:0] a_data, b_data, wd3;
  logic        a_ready, b_ready, busy1, busy2, we3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.DATA_W(32), .ADDR_W(6), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .q1(q1), .q2(q2), .busy1(busy1), .busy2(busy2),
    .we3(we3), .a3(a3), .wd3(wd3)
  );

  typedef struct {
    logic        rstn;
    logic        av;  logic [5:0] ard; logic [31:0] ad;
    logic        bv;  logic [5:0] brd; logic [31:0] bd;
    logic        iv;  logic [5:0] ird;
    logic [5:0]  q1;  logic [5:0] q2;
    logic        ear, ebr, eb1, eb2;   // before the edge
    logic        ewe, ck;              // after the edge; ck enables a3/wd3 check
    logic [5:0]  ea3; logic [31:0] ewd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic rstn, logic av, logic [5:0] ard, logic [31:0] ad,
    logic bv, logic [5:0] brd, logic [31:0] bd, logic iv, logic [5:0] ird,
    logic [5:0] xq1, logic [5:0] xq2,
    logic ear, logic ebr, logic eb1, logic eb2,
    logic ewe, logic ck, logic [5:0] ea3, logic [31:0] ewd);
    vec_t v;
    v.rstn = rstn; v.av = av; v.ard = ard; v.ad = ad;
    v.bv = bv; v.brd = brd; v.bd = bd; v.iv = iv; v.ird = ird;
    v.q1 = xq1; v.q2 = xq2;
    v.ear = ear; v.ebr = ebr; v.eb1 = eb1; v.eb2 = eb2;
    v.ewe = ewe; v.ck = ck; v.ea3 = ea3; v.ewd = ewd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge: drive, check combinational outputs,
  // cross the next edge, check the registered write port.
  task automatic apply(input vec_t v, input string tag);
    rst_n = v.rstn;
    a_valid = v.av; a_rd = v.ard; a_data = v.ad;
    b_valid = v.bv; b_rd = v.brd; b_data = v.bd;
    iss_valid = v.iv; iss_rd = v.ird; q1 = v.q1; q2 = v.q2;
    #1;
    chk({tag, " a_ready"}, 32'(a_ready), 32'(v.ear));
    chk({tag, " b_ready"}, 32'(b_ready), 32'(v.ebr));
    chk({tag, " busy1"},   32'(busy1),   32'(v.eb1));
    chk({tag, " busy2"},   32'(busy2),   32'(v.eb2));
    @(posedge clk); #1;
    chk({tag, " we3"}, 32'(we3), 32'(v.ewe));
    if (v.ck) begin
      chk({tag, " a3"},  32'(a3), 32'(v.ea3));
      chk({tag, " wd3"}, wd3, v.ewd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_valid = 0; a_rd = 0; a_data = 0; b_valid = 0; b_rd = 0; b_data = 0;
    iss_valid = 0; iss_rd = 0; q1 = 0; q2 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset we3", 32'(we3), 32'd0);
    chk("reset a3", 32'(a3), 32'd0);
    chk("reset wd3", wd3, 32'd0);
    chk("reset a_ready", 32'(a_ready), 32'd1);
    chk("reset b_ready", 32'(b_ready), 32'd1);

    // Single A write, rd=0 write, scoreboard set/clear.
    tbl.push_back(mk(1, 1,9,32'hABCDEF01, 0,0,0, 0,0, 0,0, 1,0,0,0, 1,1,9,32'hABCDEF01));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 0,0, 1,1,0,0, 0,1,9,32'hABCDEF01));
    tbl.push_back(mk(1, 1,0,32'hFFFFFFFF, 0,0,0, 1,0, 0,0, 1,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 0,0, 1,1,0,0, 0,0,0,0));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 1,3, 3,0, 1,1,0,0, 0,0,0,0));
    tbl.push_back(mk(1, 0,0,0, 1,3,32'hBABEFACE, 0,0, 3,0, 1,1,1,0, 1,1,3,32'hBABEFACE));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 3,0, 1,1,0,0, 0,1,3,32'hBABEFACE));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 1,5, 3,5, 1,1,0,0, 0,1,3,32'hBABEFACE));
    tbl.push_back(mk(1, 0,0,0, 1,5,32'h12345678, 1,5, 3,5, 1,1,0,1, 1,1,5,32'h12345678));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 3,5, 1,1,0,1, 0,1,5,32'h12345678));
    tbl.push_back(mk(1, 1,5,32'h0000AAAA, 0,0,0, 0,0, 3,5, 1,0,0,1, 1,1,5,32'h0000AAAA));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 3,5, 1,1,0,1, 0,1,5,32'h0000AAAA));
    tbl.push_back(mk(1, 0,0,0, 1,5,32'h55555555, 0,0, 3,5, 1,1,0,1, 1,1,5,32'h55555555));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 3,5, 1,1,0,0, 0,1,5,32'h55555555));
    // Two rounds of continuous contention: four A grants then one B grant.
    for (int r = 0; r < 2; r++) begin
      for (int j = 1; j <= 4; j++)
        tbl.push_back(mk(1, 1,6'(j),32'hA0000000 + 32'(j), 1,7,32'hB0B0B0B0, 0,0, 0,0,
                         1,0,0,0, 1,1,6'(j),32'hA0000000 + 32'(j)));
      tbl.push_back(mk(1, 1,8,32'hA8, 1,7,32'hB0B0B0B0, 0,0, 0,0, 0,1,0,0, 1,1,7,32'hB0B0B0B0));
    end
    // Build starve_cnt=3 with a busy bit set, then reset with a live handshake.
    tbl.push_back(mk(1, 1,10,32'hC1, 1,7,32'hB0B0B0B0, 1,9, 9,0, 1,0,0,0, 1,1,10,32'hC1));
    tbl.push_back(mk(1, 1,11,32'hC2, 1,7,32'hB0B0B0B0, 0,0, 9,0, 1,0,1,0, 1,1,11,32'hC2));
    tbl.push_back(mk(1, 1,12,32'hC3, 1,7,32'hB0B0B0B0, 0,0, 9,0, 1,0,1,0, 1,1,12,32'hC3));
    tbl.push_back(mk(0, 1,13,32'hC4, 1,7,32'hB0B0B0B0, 0,0, 9,0, 1,0,1,0, 0,1,0,0));
    // After reset the counter restarts: four A grants before B is forced.
    for (int j = 0; j < 4; j++)
      tbl.push_back(mk(1, 1,6'(14 + j),32'hC5 + 32'(j), 1,7,32'hB0B0B0B0, 0,0, 9,0,
                       1,0,0,0, 1,1,6'(14 + j),32'hC5 + 32'(j)));
    tbl.push_back(mk(1, 1,18,32'hC9, 1,7,32'hB0B0B0B0, 0,0, 9,0, 0,1,0,0, 1,1,7,32'hB0B0B0B0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Hand sequence: enter B_PRI, then B withdraws; A is served and A_PRI resumes.
    for (int j = 0; j < 4; j++)
      apply(mk(1, 1,6'(20 + j),32'hD0 + 32'(j), 1,7,32'hB0B0B0B0, 0,0, 0,0,
               1,0,0,0, 1,1,6'(20 + j),32'hD0 + 32'(j)), $sformatf("starve%0d", j));
    apply(mk(1, 1,24,32'hD4, 0,0,0, 0,0, 0,0, 1,1,0,0, 1,1,24,32'hD4), "bpri_b_idle");
    apply(mk(1, 1,25,32'hD5, 1,7,32'hB0B0B0B0, 0,0, 0,0, 1,0,0,0, 1,1,25,32'hD5), "apri_back");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
